// File: rtl/instr_issuer_pkg.sv
// Shared instruction-word layout, FSM encoding and field helpers for instr_issuer.
// ISSUER_HAZARD_STALL_EN adds the STALL state encoding.
package instr_issuer_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 13;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned REG_W   = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef ISSUER_HAZARD_STALL_EN
  localparam logic [1:0] ST_STALL = 2'd3;
`endif

  function automatic logic [OPC_W-1:0] opc_of(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] w);
    return w[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs1_of(input logic [INSTR_W-1:0] w);
    return w[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs2_of(input logic [INSTR_W-1:0] w);
    return w[RS2_LSB +: REG_W];
  endfunction

  // True when nxt reads the register that prev writes.
  function automatic logic raw_hazard(input logic [INSTR_W-1:0] prev,
                                      input logic [INSTR_W-1:0] nxt);
    return (rs1_of(nxt) == rd_of(prev)) || (rs2_of(nxt) == rd_of(prev));
  endfunction

endpackage

// File: rtl/instr_issuer_prog_ram.sv
// Program buffer: DEPTH x INSTR_W, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module issue_prog_ram
  import instr_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic               clock,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Program sequencer issuing buffered 18-bit instructions over valid/ready, with repeats.
// Optional ISSUER_HAZARD_STALL_EN inserts a bubble on a dest->src register dependency.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned RPT_W = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [AW-1:0]      prog_len,
  input  logic [RPT_W-1:0]   repeat_cnt,
  input  logic               abort,
  input  logic               exec_ready,
  output logic [INSTR_W-1:0] instruct,
  output logic               instr_valid,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW-1:0]      len_q, len_d;
  logic [RPT_W-1:0]   passes_q, passes_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [AW-1:0]      rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               transfer;
  logic               last_word;

  issue_prog_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clock(clock),
    .we   (load_en && (state_q == ST_IDLE)),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign transfer  = valid_q && exec_ready;
  assign last_word = (pc_q == len_q);

  // Read port always points at the word that follows the current one.
  always_comb begin
    rd_addr = '0;
    if (state_q != ST_IDLE && !last_word) rd_addr = pc_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    passes_d = passes_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          len_d    = prog_len;
          passes_d = repeat_cnt;
          pc_d     = '0;
          instr_d  = rd_data;
          valid_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (transfer) begin
          if (!last_word || passes_q != '0) begin
            if (last_word) passes_d = passes_q - 1'b1;
            pc_d    = rd_addr;
            instr_d = rd_data;
`ifdef ISSUER_HAZARD_STALL_EN
            if (raw_hazard(instr_q, rd_data)) begin
              valid_d = 1'b0;
              state_d = ST_STALL;
            end
`endif
          end else begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
`ifdef ISSUER_HAZARD_STALL_EN
      ST_STALL: begin
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (abort && state_q != ST_IDLE) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      passes_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign instruct    = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus randomized runs
// checked against an expected-index-queue model of the program buffer.
module tb_instr_issuer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RPT_W = 8;
  localparam int IW    = 18;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             load_en = 1'b0;
  logic [AW-1:0]    load_addr = '0;
  logic [IW-1:0]    load_data = '0;
  logic             start = 1'b0;
  logic [AW-1:0]    prog_len = '0;
  logic [RPT_W-1:0] repeat_cnt = '0;
  logic             abort = 1'b0;
  logic             exec_ready = 1'b0;
  logic [IW-1:0]    instruct;
  logic             instr_valid;
  logic [AW-1:0]    pc;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;
  logic [IW-1:0] model_mem [DEPTH];

  instr_issuer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .RPT_W(RPT_W)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .prog_len   (prog_len),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .exec_ready (exec_ready),
    .instruct   (instruct),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int addr, input logic [IW-1:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    model_mem[addr] = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_instruct"}, instruct, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Runs one program; expected issue order is every index 0..len, repeated rpt+1 times.
  // exp_gaps < 0 skips the bubble count; hold_at >= 0 withholds ready 3 cycles at that pc.
  task automatic run_prog(input int len, input int rpt, input bit rnd, input int hold_at,
                          input int exp_gaps);
    int idx[$];
    int k, gaps, held, guard;
    bit rdy, stalled_prev;
    logic [IW-1:0] prev;
    for (int p = 0; p <= rpt; p++)
      for (int i = 0; i <= len; i++) idx.push_back(i);
    prog_len   = AW'(len);
    repeat_cnt = RPT_W'(rpt);
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("first_valid", instr_valid, 1);
    k = 0; gaps = 0; held = 0; guard = 0; stalled_prev = 1'b0; prev = '0;
    while (k < idx.size() && guard < 4000) begin
      guard++;
      chk("run_busy", busy, 1);
      chk("run_done_early", done, 0);
      if (instr_valid) begin
        chk("run_word", instruct, model_mem[idx[k]]);
        chk("run_pc", pc, idx[k]);
        if (stalled_prev) chk("hold_stable", instruct, prev);
      end else begin
        gaps++;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_at >= 0 && instr_valid && int'(pc) == hold_at && k <= len && held < 3) begin
        rdy = 1'b0;
        held++;
      end
      exec_ready   = rdy;
      stalled_prev = instr_valid && !rdy;
      prev         = instruct;
      if (instr_valid && rdy) k++;
      @(negedge clock);
    end
    chk("run_complete", k, idx.size());
    chk("end_done", done, 1);
    chk("end_valid", instr_valid, 0);
    chk("end_busy", busy, 1);
    @(negedge clock);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    if (exp_gaps >= 0) chk("gap_count", gaps, exp_gaps);
    if (hold_at >= 0) chk("hold_cycles", held, 3);
  endtask

  initial begin
    int len, rpt;
    repeat (2) @(negedge clock);
    chk_idle_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);

    // Main directed program: no register dependencies between neighbours, so no bubbles.
    load_word(0, 18'h00011);
    load_word(1, 18'h00109);
    load_word(2, 18'h2A31A);
    run_prog(2, 1, 1'b0, -1, 0);

    // Ready withheld three cycles at pc=1.
    run_prog(2, 1, 1'b0, 1, -1);

    // Reset mid-run, then a fresh run from buf[0].
    prog_len = 2; repeat_cnt = 3; exec_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk_idle_outputs("released");
    run_prog(2, 0, 1'b0, -1, 0);

    // Abort at pc=1 with start and a buffer write in the same cycle.
    prog_len = 2; repeat_cnt = 0; exec_ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("abort_pc", pc, 1);
    abort = 1'b1; start = 1'b1; load_en = 1'b1; load_addr = '0; load_data = 18'h3FFFF;
    @(negedge clock);
    abort = 1'b0; start = 1'b0; load_en = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", instr_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clock);
    chk("abort_start_ignored", busy, 0);
    chk("abort_no_done", done, 0);
    run_prog(2, 0, 1'b0, -1, 0);

    // Single-instruction program.
    load_word(0, 18'h0001F);
    run_prog(0, 0, 1'b0, -1, 0);

    // Dest of word0 is src1 of word1.
    load_word(0, 18'h00028);
    load_word(1, 18'h00500);
`ifdef ISSUER_HAZARD_STALL_EN
    run_prog(1, 0, 1'b0, -1, 1);
`else
    run_prog(1, 0, 1'b0, -1, 0);
`endif

    // Randomized programs and ready patterns.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, DEPTH - 1);
      rpt = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) load_word(i, IW'($urandom));
      run_prog(len, rpt, 1'b1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Program sequencer that drives the 18-bit instruction bus of the register-file/ALU/shifter datapath. It holds a small loadable program buffer. On start it issues the stored instruction words in order over a valid/ready handshake, repeats the program a configured number of times, then pulses done. It sits upstream of the datapath and is the producer end of the instruction interface that the datapath consumes.

## Interface
- DEPTH, 16: program buffer entries; power of two.
- AW, 4: address width, log2(DEPTH).
- RPT_W, 8: repeat counter width.

- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous reset, active-low.
- load_en  in  1  write load_data to buffer[load_addr]; honoured only while busy=0.
- load_addr  in  AW  buffer write index.
- load_data  in  18  instruction word: [2:0] opcode, [7:3] dest reg, [12:8] src1 reg, [17:13] shift amount / src2 reg.
- start  in  1  begin a run; honoured only while busy=0.
- prog_len  in  AW  index of last instruction; program is entries 0..prog_len.
- repeat_cnt  in  RPT_W  extra passes; total passes = repeat_cnt+1.
- abort  in  1  terminate the run.
- exec_ready  in  1  datapath accepts the instruct word this cycle.
- instruct  out  18  registered instruction word.
- instr_valid  out  1  instruct is valid.
- pc  out  AW  index of the word currently on instruct.
- busy  out  1  run in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse at normal run completion.

## Operation
- States: IDLE, ISSUE, STALL (macro only), DONE.
- IDLE:
  - load_en writes the buffer.
  - start captures prog_len into len_q and repeat_cnt into passes_left.
  - It also sets pc=0, instruct=buf[0], instr_valid=1, and moves to ISSUE.
- ISSUE: a transfer occurs when instr_valid && exec_ready.
  - Transfer with pc<len_q: pc+1, instruct=buf[pc+1].
  - Transfer with pc==len_q and passes_left>0: passes_left-1, pc=0, instruct=buf[0].
  - Transfer with pc==len_q and passes_left==0: instr_valid=0, go to DONE.
- Without a transfer, instruct, pc and instr_valid hold. Changing the payload while valid and not ready is forbidden.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort, sampled in any non-IDLE state, forces IDLE on the next edge with instr_valid=0 and no done pulse. Any handshake in that same cycle counts as transferred.
- In IDLE, abort has priority over start; start is ignored that cycle.
- load_en, start, prog_len and repeat_cnt are ignored while busy=1. Captured values are stable for the whole run.
- prog_len=0 is legal: a single-instruction program.
- pc arithmetic is AW-bit. pc never exceeds len_q.
- The buffer is not reset. Issuing unloaded entries gives undefined words, but control behaviour is unaffected.

## Timing
- Reset values: instruct=0, instr_valid=0, pc=0, busy=0, done=0, state=IDLE, passes_left=0, len_q=0.
- start sampled at edge N: instr_valid=1 with buf[0] after edge N.
- With exec_ready held high, throughput is one instruction per cycle, including the wrap from the last index back to 0.
- A run of P words × R passes with ready held high ends as follows:
  - instr_valid is high for P·R consecutive cycles.
  - done is high the cycle after the last transfer.
  - busy falls the cycle after done.
- busy is combinational from state and rises the cycle after start.

## Configuration
- ISSUER_HAZARD_STALL_EN defined: a STALL cycle is inserted after a transfer when the next word's [12:8] or [17:13] equals the transferred word's [7:3].
  - During the STALL cycle instr_valid=0 and the next word is held internally; ISSUE resumes the following cycle.
  - The check also applies across the pass wrap.
- Not defined: no STALL state, no comparison, and back-to-back issue always.

## Structure
- Package instr_issuer_pkg holds:
  - field position localparams: OPC_LSB=0, RD_LSB=3, RS1_LSB=8, RS2_LSB=13, field widths 3/5;
  - the state enum;
  - the INSTR_W=18 constant.
- Sub-module issue_prog_ram: DEPTH×18 storage with one synchronous write port and one asynchronous read port, not reset.

## Test plan
- Reset mid-run, then release: all outputs 0, state IDLE. A new start then issues buf[0] normally.
- Load 0x00011, 0x00109, 0x2A31A at indices 0..2; prog_len=2, repeat_cnt=1, exec_ready=1.
  - Required: instruct sequence 0x00011, 0x00109, 0x2A31A, 0x00011, 0x00109, 0x2A31A on 6 consecutive cycles.
  - Required: done one cycle later, busy low one cycle after that.
- Same program with exec_ready low for 3 cycles at pc=1: instruct=0x00109 and pc=1 stay stable. Resume completes with no lost or duplicated word.
- prog_len=0, repeat_cnt=0, word 0x0001F: exactly one valid cycle, then done.
- abort asserted at pc=1 of the pass-0 run:
  - IDLE next cycle, no done pulse, start ignored the same cycle.
  - load_en while busy leaves buffer contents unchanged.
- With ISSUER_HAZARD_STALL_EN, word0 dest=5 and word1 src1=5: one instr_valid=0 cycle between them. Without the macro there is no gap.
